morse_symbol_decoder: RTL and testbench

Front-end stage of the Morse receiver. Filters the raw key input, times key-down and key-up intervals in Morse units, and assembles dots and dashes into a marker-prefixed character code. At the end of each character it emits the code with a one-cycle rdy strobe. At the end of each word it emits an en/ws strobe pair. Both feed the downstream code-to-ASCII mapping stage.

---
 rtl/morse_symbol_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_morse_symbol_decoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_symbol_decoder.sv
// morse_symbol_decoder
// Front end of the Morse receiver: conditions the raw key, measures key-down
// and key-up intervals in Morse units, and assembles dots/dashes into a
// marker-prefixed character code. Emits rdy with the code at the end of each
// character, err when a character had too many symbols, and an en/ws pair at
// each word boundary.
module morse_symbol_decoder #(
    parameter int UNIT_CLKS      = 1000,
    parameter int DEBOUNCE_CLKS  = 16,
    parameter int DASH_UNITS     = 2,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 7,
    parameter int MAX_SYMBOLS    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_in,
    output logic [7:0] data,
    output logic       rdy,
    output logic       en,
    output logic       ws,
    output logic       err
);

    localparam int PW = (UNIT_CLKS > 2) ? $clog2(UNIT_CLKS) : 1;
    localparam int DW = $clog2(DEBOUNCE_CLKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        WAIT_WORD
    } state_t;

    logic [1:0]    sync_reg;
    logic          filt_reg;
    logic          filt_prev_reg;
    logic [DW-1:0] db_cnt_reg;
    logic [PW-1:0] presc_reg;
    logic [7:0]    units_reg;

    state_t        state_reg;
    logic [7:0]    code_reg;
    logic [3:0]    sym_cnt_reg;
    logic          ovf_reg;
    logic          word_pending_reg;
    logic [7:0]    data_reg;
    logic          rdy_reg;
    logic          en_reg;
    logic          ws_reg;
    logic          err_reg;

    logic rise;
    logic fall;
    logic key_event;
    logic tick;
    logic char_tick;
    logic word_tick;
    logic sym_bit;

    // Two-stage synchronizer for the asynchronous key
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], key_in};
        end
    end

    // Debounce: the mismatch must already have lasted DEBOUNCE_CLKS cycles;
    // the filtered level flips on the next still-mismatched cycle, so a pulse
    // of DEBOUNCE_CLKS cycles or less never gets through.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_reg      <= 1'b0;
            filt_prev_reg <= 1'b0;
            db_cnt_reg    <= '0;
        end else begin
            filt_prev_reg <= filt_reg;
            if (sync_reg[1] != filt_reg) begin
                if (db_cnt_reg == DW'(DEBOUNCE_CLKS)) begin
                    filt_reg   <= sync_reg[1];
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + DW'(1);
                end
            end else begin
                db_cnt_reg <= '0;
            end
        end
    end

    assign rise      = filt_reg & ~filt_prev_reg;
    assign fall      = ~filt_reg & filt_prev_reg;
    assign key_event = rise | fall;
    assign tick      = (presc_reg == PW'(UNIT_CLKS - 1));
    // Compare against the count before this tick lands, so the decision is
    // registered one cycle after the tick that completes the interval.
    assign char_tick = tick && (units_reg == 8'(CHAR_GAP_UNITS - 1));
    assign word_tick = tick && (units_reg == 8'(WORD_GAP_UNITS - 1));
    assign sym_bit   = (units_reg >= 8'(DASH_UNITS));

    // Unit prescaler and saturating unit counter, both restarted by key edges
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg <= '0;
            units_reg <= 8'h00;
        end else if (key_event) begin
            presc_reg <= '0;
            units_reg <= 8'h00;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick && (units_reg != 8'hFF)) begin
                units_reg <= units_reg + 8'h01;
            end
        end
    end

    // Symbol/character/word sequencer with registered strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            code_reg         <= 8'h00;
            sym_cnt_reg      <= 4'd0;
            ovf_reg          <= 1'b0;
            word_pending_reg <= 1'b0;
            data_reg         <= 8'h00;
            rdy_reg          <= 1'b0;
            en_reg           <= 1'b0;
            ws_reg           <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            rdy_reg <= 1'b0;
            en_reg  <= 1'b0;
            ws_reg  <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        code_reg    <= 8'h01;
                        sym_cnt_reg <= 4'd0;
                        state_reg   <= PRESS;
                    end
                end
                PRESS: begin
                    if (fall) begin
                        code_reg <= {code_reg[6:0], sym_bit};
                        if (sym_cnt_reg != 4'hF) begin
                            sym_cnt_reg <= sym_cnt_reg + 4'd1;
                        end
                        if (sym_cnt_reg >= 4'(MAX_SYMBOLS)) begin
                            ovf_reg <= 1'b1;
                        end
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    if (char_tick) begin
                        if (ovf_reg) begin
                            err_reg <= 1'b1;
                        end else begin
                            data_reg <= code_reg;
                            rdy_reg  <= 1'b1;
                        end
                        ovf_reg          <= 1'b0;
                        word_pending_reg <= 1'b1;
                        if (rise) begin
                            code_reg    <= 8'h01;
                            sym_cnt_reg <= 4'd0;
                            state_reg   <= PRESS;
                        end else begin
                            state_reg <= WAIT_WORD;
                        end
                    end else if (rise) begin
                        state_reg <= PRESS;
                    end
                end
                WAIT_WORD: begin
                    if (word_tick && word_pending_reg) begin
                        en_reg           <= 1'b1;
                        ws_reg           <= 1'b1;
                        word_pending_reg <= 1'b0;
                        if (rise) begin
                            code_reg    <= 8'h01;
                            sym_cnt_reg <= 4'd0;
                            state_reg   <= PRESS;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (rise) begin
                        code_reg    <= 8'h01;
                        sym_cnt_reg <= 4'd0;
                        state_reg   <= PRESS;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign data = data_reg;
    assign rdy  = rdy_reg;
    assign en   = en_reg;
    assign ws   = ws_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Bench for morse_symbol_decoder: directed scenarios plus random keying,
// with all strobes compared against an interval-level reference model.
module tb_morse_symbol_decoder;

    localparam int U    = 4;
    localparam int DEB  = 2;
    localparam int DASH = 2;
    localparam int CG   = 3;
    localparam int WG   = 7;
    localparam int MAXS = 6;

    localparam int K_RDY = 0;
    localparam int K_ERR = 1;
    localparam int K_EN  = 2;

    localparam int EV_RISE  = 0;
    localparam int EV_FALL  = 1;
    localparam int EV_RESET = 2;
    localparam int EV_END   = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] d;
        logic       w;
    } strobe_t;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       key_in = 1'b0;
    logic [7:0] data;
    logic       rdy;
    logic       en;
    logic       ws;
    logic       err;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    bit      kin_q[$];
    bit      rst_q[$];
    strobe_t obs_q[$];
    strobe_t exp_q[$];
    logic [7:0] prev_data = 8'h00;

    morse_symbol_decoder #(
        .UNIT_CLKS     (U),
        .DEBOUNCE_CLKS (DEB),
        .DASH_UNITS    (DASH),
        .CHAR_GAP_UNITS(CG),
        .WORD_GAP_UNITS(WG),
        .MAX_SYMBOLS   (MAXS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key_in(key_in),
        .data  (data),
        .rdy   (rdy),
        .en    (en),
        .ws    (ws),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Record what the DUT sampled at every edge
    always @(posedge clk) begin
        kin_q.push_back(key_in);
        rst_q.push_back(reset);
    end

    // Log strobes and per-cycle output invariants
    always @(negedge clk) begin
        int m;
        m = kin_q.size() - 1;
        if (reset) begin
            prev_data = data;
        end else begin
            if ((int'(rdy) + int'(err) + int'(en)) > 1) viol++;
            if (ws != en) viol++;
            if ((data != prev_data) && !rdy) viol++;
            prev_data = data;
            if (rdy) begin
                obs_q.push_back('{m, K_RDY, data, ws});
                $display("cyc %0d rdy data=%02h", m, data);
            end else if (err) begin
                obs_q.push_back('{m, K_ERR, data, ws});
                $display("cyc %0d err data=%02h", m, data);
            end else if (en) begin
                obs_q.push_back('{m, K_EN, data, ws});
                $display("cyc %0d en ws=%0b", m, ws);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic hold(input bit lvl, input int n);
        key_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sym(input bit dash);
        hold(1'b1, dash ? 3 * U : U);
    endtask

    task automatic do_reset(input int n, input string tag);
        key_in = 1'b0;
        reset  = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check(tag, {data, rdy, en, ws, err}, 32'h0);
        reset = 1'b0;
    endtask

    function automatic int count_kind(input int from, input int kind);
        int c = 0;
        for (int i = from; i < obs_q.size(); i++) if (obs_q[i].kind == kind) c++;
        return c;
    endfunction

    function automatic logic [7:0] nth_rdy_data(input int from, input int nth);
        int c = 0;
        for (int i = from; i < obs_q.size(); i++) begin
            if (obs_q[i].kind == K_RDY) begin
                if (c == nth) return obs_q[i].d;
                c++;
            end
        end
        return 8'h00;
    endfunction

    function automatic int first_cyc(input int from, input int kind, input int nth);
        int c = 0;
        for (int i = from; i < obs_q.size(); i++) begin
            if (obs_q[i].kind == kind) begin
                if (c == nth) return obs_q[i].cyc;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic logic [31:0] pack(input strobe_t s);
        logic [31:0] c;
        logic [31:0] k;
        c = s.cyc;
        k = s.kind;
        return {c[19:0], k[3:0], s.d};
    endfunction

    // A strobe tied to an interval ending at 'tick' survives if the next
    // rise is no earlier than the tick, or if it is registered before a
    // reset / the end of observation.
    function automatic bit reaches(input int tick, input int nk, input int nc);
        if (nk == EV_RISE) return (tick <= nc);
        return (tick + 1 < nc);
    endfunction

    // Reference model: derive filtered key edges from the sampled key,
    // then turn key-down/key-up interval lengths into expected strobes.
    function automatic void run_model();
        int         n;
        bit         s_arr[];
        bit         fv[];
        bit         f;
        bit         flip;
        ev_t        evs[$];
        logic [7:0] code;
        logic [7:0] held;
        int         cnt;
        bit         open;
        int         rise_cyc;
        int         units;
        int         nk;
        int         nc;
        int         tc;
        int         tw;

        n     = kin_q.size();
        s_arr = new[n];
        fv    = new[n];
        f     = 1'b0;
        for (int m = 0; m < n; m++) begin
            if (m < 2) s_arr[m] = 1'b0;
            else if (rst_q[m-1] || rst_q[m-2]) s_arr[m] = 1'b0;
            else s_arr[m] = kin_q[m-2];
            if (rst_q[m]) begin
                f = 1'b0;
            end else if (m >= DEB) begin
                flip = 1'b1;
                for (int j = 0; j <= DEB; j++) if (s_arr[m-j] == f) flip = 1'b0;
                if (flip) f = ~f;
            end
            fv[m] = f;
        end

        for (int m = 0; m < n; m++) begin
            if (rst_q[m] && (m == 0 || !rst_q[m-1])) evs.push_back('{m, EV_RESET});
            else if (!rst_q[m] && m > 0 && fv[m] != fv[m-1])
                evs.push_back('{m, fv[m] ? EV_RISE : EV_FALL});
        end

        code     = 8'h01;
        held     = 8'h00;
        cnt      = 0;
        open     = 1'b0;
        rise_cyc = 0;
        for (int i = 0; i < evs.size(); i++) begin
            if (evs[i].kind == EV_RESET) begin
                open = 1'b0;
                held = 8'h00;
            end else if (evs[i].kind == EV_RISE) begin
                if (!open) begin
                    code = 8'h01;
                    cnt  = 0;
                    open = 1'b1;
                end
                rise_cyc = evs[i].cyc;
            end else begin
                units = (evs[i].cyc - rise_cyc - 1) / U;
                if (units > 255) units = 255;
                code = {code[6:0], (units >= DASH)};
                cnt++;
                if (i + 1 < evs.size()) begin
                    nk = evs[i+1].kind;
                    nc = evs[i+1].cyc;
                end else begin
                    nk = EV_END;
                    nc = n;
                end
                tc = evs[i].cyc + CG * U;
                tw = evs[i].cyc + WG * U;
                if (reaches(tc, nk, nc)) begin
                    if (cnt > MAXS) begin
                        exp_q.push_back('{tc + 1, K_ERR, held, 1'b0});
                    end else begin
                        held = code;
                        exp_q.push_back('{tc + 1, K_RDY, code, 1'b0});
                    end
                    open = 1'b0;
                    if (reaches(tw, nk, nc)) exp_q.push_back('{tw + 1, K_EN, held, 1'b1});
                end
            end
        end
    endfunction

    initial begin
        int start;
        int nsym;
        int a;

        reset  = 1'b1;
        key_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset outputs", {data, rdy, en, ws, err}, 32'h0);
        reset = 1'b0;
        hold(1'b0, 5 * U);

        // 1: A = dot dash
        start = obs_q.size();
        sym(1'b0); hold(1'b0, U); sym(1'b1); hold(1'b0, 10 * U);
        check("s1 rdy count", count_kind(start, K_RDY), 1);
        check("s1 data A", nth_rdy_data(start, 0), 8'h05);
        check("s1 en count", count_kind(start, K_EN), 1);
        check("s1 rdy-to-en spacing",
              first_cyc(start, K_EN, 0) - first_cyc(start, K_RDY, 0), (WG - CG) * U);

        // 2: E, 4-unit gap, T
        start = obs_q.size();
        sym(1'b0); hold(1'b0, 4 * U); sym(1'b1); hold(1'b0, 10 * U);
        check("s2 rdy count", count_kind(start, K_RDY), 2);
        check("s2 data E", nth_rdy_data(start, 0), 8'h02);
        check("s2 data T", nth_rdy_data(start, 1), 8'h03);
        check("s2 en count", count_kind(start, K_EN), 1);
        check("s2 en after T", first_cyc(start, K_EN, 0) > first_cyc(start, K_RDY, 1), 1);

        // 3: Q, then a 7-symbol character
        start = obs_q.size();
        sym(1'b1); hold(1'b0, U); sym(1'b1); hold(1'b0, U);
        sym(1'b0); hold(1'b0, U); sym(1'b1); hold(1'b0, 10 * U);
        check("s3 data Q", nth_rdy_data(start, 0), 8'h1D);
        start = obs_q.size();
        for (int i = 0; i < 7; i++) begin
            sym(1'b0);
            hold(1'b0, (i == 6) ? 10 * U : U);
        end
        check("s3 err count", count_kind(start, K_ERR), 1);
        check("s3 rdy count", count_kind(start, K_RDY), 0);
        check("s3 data held", data, 8'h1D);

        // 4: glitches
        start = obs_q.size();
        hold(1'b1, 1); hold(1'b0, 10 * U);
        hold(1'b1, 2); hold(1'b0, 10 * U);
        check("s4 no strobes", obs_q.size() - start, 0);
        start = obs_q.size();
        hold(1'b1, 4); hold(1'b0, 10 * U);
        check("s4 glitch dot", nth_rdy_data(start, 0), 8'h02);

        // 5: reset in the middle of D, then N
        sym(1'b1); hold(1'b0, U); hold(1'b1, 6);
        do_reset(3, "s5 reset outputs");
        hold(1'b0, 3 * U);
        start = obs_q.size();
        sym(1'b1); hold(1'b0, U); sym(1'b0); hold(1'b0, 10 * U);
        check("s5 rdy count", count_kind(start, K_RDY), 1);
        check("s5 data N", nth_rdy_data(start, 0), 8'h06);

        // 6: key held 300 units
        start = obs_q.size();
        hold(1'b1, 300 * U); hold(1'b0, 10 * U);
        check("s6 data", nth_rdy_data(start, 0), 8'h03);
        check("s6 rdy count", count_kind(start, K_RDY), 1);
        check("s6 en count", count_kind(start, K_EN), 1);

        // Random keying with bounces, boundary gaps and occasional resets
        for (int c = 0; c < 30; c++) begin
            nsym = $urandom_range(1, 7);
            for (int s = 0; s < nsym; s++) begin
                if ($urandom_range(0, 7) == 0) begin
                    a = $urandom_range(3, 7);
                    hold(1'b1, a);
                    hold(1'b0, $urandom_range(1, 2));
                    hold(1'b1, $urandom_range(3, 7));
                end else begin
                    hold(1'b1, $urandom_range(3, 14));
                end
                if (s != nsym - 1) hold(1'b0, $urandom_range(3, 11));
            end
            hold(1'b0, $urandom_range(10, 40));
            if ($urandom_range(0, 14) == 0) do_reset(2, "rand reset outputs");
        end
        hold(1'b0, 12 * U);

        run_model();
        check("strobe count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check($sformatf("strobe %0d cyc/kind/data", i), pack(obs_q[i]), pack(exp_q[i]));
        check("output invariants", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
